multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 83 ++++++++
 rtl/mc_output_decode.sv | 75 +++++++
 rtl/multicycle_control.sv | 114 +++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle processor control unit.
// Holds the FSM state encoding, the opcode map, the ALU operation class
// codes, the operand/PC select codes, the bundled control word and an
// opcode classifier used by the next-state logic.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_HALT   = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    IC_LW   = 3'd0,
    IC_SW   = 3'd1,
    IC_ALU  = 3'd2,
    IC_BEQ  = 3'd3,
    IC_J    = 3'd4,
    IC_HALT = 3'd5,
    IC_NOP  = 3'd6
  } iclass_t;

  localparam logic [3:0] OPC_LW     = 4'b0000;
  localparam logic [3:0] OPC_SW     = 4'b0001;
  localparam logic [3:0] OPC_ALU_LO = 4'b0010;
  localparam logic [3:0] OPC_ALU_HI = 4'b1001;
  localparam logic [3:0] OPC_BEQ    = 4'b1010;
  localparam logic [3:0] OPC_J      = 4'b1011;

  localparam logic [1:0] OP_FUNC = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  // Fixed opcodes take precedence over the halt opcode so that a
  // reparameterised halt code can never steal a real instruction.
  function automatic iclass_t classify(input logic [3:0] opc,
                                       input logic [3:0] halt_opc);
    iclass_t c;
    if (opc == OPC_LW)                              c = IC_LW;
    else if (opc == OPC_SW)                         c = IC_SW;
    else if (opc >= OPC_ALU_LO && opc <= OPC_ALU_HI) c = IC_ALU;
    else if (opc == OPC_BEQ)                        c = IC_BEQ;
    else if (opc == OPC_J)                          c = IC_J;
    else if (opc == halt_opc)                       c = IC_HALT;
    else                                            c = IC_NOP;
    return c;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decoder for the multicycle control FSM.
// Ports:
//   i_state     current FSM state
//   i_mem_ready memory handshake (qualifies IR/PC writes in FETCH)
//   o_ctrl      full datapath control word, zero for anything not driven
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_ONE;
        o_ctrl.op        = OP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        // IR load and PC+1 commit only when the fetch read completes.
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = SRCB_BOFF;
        o_ctrl.op        = OP_ADD;
      end
      ST_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.op        = OP_ADD;
      end
      ST_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.op        = OP_FUNC;
      end
      ST_ALUWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.op        = OP_FUNC;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.op            = OP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      ST_HALT: begin
        o_ctrl.halted = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit.
// Registered-state FSM sequencing FETCH/DECODE and the per-class execute
// states, plus a 16-bit retired-instruction counter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   Opcode            IR opcode, sampled at the DECODE and MEMADR edges
//   mem_ready         memory read/write completes this cycle
//   Op, ALUSrcB, PCSource and the single-bit datapath controls
//   halted            high while parked in HALT
//   instr_count       retired instruction count (wraps)
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Opcode,
  input  logic        mem_ready,
  output logic [1:0]  Op,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        halted,
  output logic [15:0] instr_count
);

  state_t      r_state;
  state_t      w_next;
  iclass_t     w_class;
  logic        w_retire;
  logic [15:0] r_instr_count;
  ctrl_t       w_ctrl;
  ctrl_t       w_ctrl_out;

  assign w_class = classify(Opcode, HALT_OPCODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FETCH:  if (mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        unique case (w_class)
          IC_LW, IC_SW: w_next = ST_MEMADR;
          IC_ALU:       w_next = ST_EXEC;
          IC_BEQ:       w_next = ST_BRANCH;
          IC_J:         w_next = ST_JUMP;
          IC_HALT:      w_next = ST_HALT;
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEMADR: w_next = (w_class == IC_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) w_next = ST_MEMWB;
      ST_MEMWB:  w_next = ST_FETCH;
      ST_MEMWR:  if (mem_ready) w_next = ST_FETCH;
      ST_EXEC:   w_next = ST_ALUWB;
      ST_ALUWB:  w_next = ST_FETCH;
      ST_BRANCH: w_next = ST_FETCH;
      ST_JUMP:   w_next = ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Every path back into FETCH from another state completes an instruction;
  // FETCH waiting on memory and HALT never do.
  assign w_retire = (r_state != ST_FETCH) && (w_next == ST_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instr_count <= 16'd0;
    else if (w_retire) r_instr_count <= r_instr_count + 16'd1;
  end

  mc_output_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // The state register already reads FETCH during reset, so the control
  // word is masked to keep the datapath quiet until reset is released.
  assign w_ctrl_out = rst ? '0 : w_ctrl;

  assign Op          = w_ctrl_out.op;
  assign PCWrite     = w_ctrl_out.pc_write;
  assign PCWriteCond = w_ctrl_out.pc_write_cond;
  assign IorD        = w_ctrl_out.i_or_d;
  assign MemRead     = w_ctrl_out.mem_read;
  assign MemWrite    = w_ctrl_out.mem_write;
  assign IRWrite     = w_ctrl_out.ir_write;
  assign MemToReg    = w_ctrl_out.mem_to_reg;
  assign RegWrite    = w_ctrl_out.reg_write;
  assign RegDst      = w_ctrl_out.reg_dst;
  assign ALUSrcA     = w_ctrl_out.alu_src_a;
  assign ALUSrcB     = w_ctrl_out.alu_src_b;
  assign PCSource    = w_ctrl_out.pc_source;
  assign halted      = w_ctrl_out.halted;
  assign instr_count = r_instr_count;

endmodule
